// File: rtl/me_plane_ctrl_pkg.sv
// me_plane_ctrl_pkg: shared screen/object geometry, bullet mode codes and plane FSM encodings
package me_plane_ctrl_pkg;
  localparam int OBJ_X_POS_BIT_LEN = 10;
  localparam int OBJ_Y_POS_BIT_LEN = 9;
  localparam int ME_WIDTH = 50;
  localparam int ME_HEIGHT = 50;
  localparam int H_DISP = 640;
  localparam int V_DISP = 480;
  localparam logic BULLET_MODE_SINGLE = 1'b0;
  localparam logic BULLET_MODE_DOUBLE = 1'b1;
  localparam logic [0:0] S_SINGLE = 1'b0;
  localparam logic [0:0] S_DOUBLE = 1'b1;
  localparam int MOVE_DIV_DEF = 1_000_000;
  localparam int CNT_MAX_MOVE = MOVE_DIV_DEF - 1;
endpackage

// File: rtl/me_plane_ctrl_if.sv
// me_plane_ctrl_if: key/enable/power-up inputs and plane position/mode/tick outputs of the plane controller
interface me_plane_ctrl_if;
  import me_plane_ctrl_pkg::*;
  logic key_up;
  logic key_down;
  logic key_left;
  logic key_right;
  logic enable;
  logic powerup;
  logic [OBJ_X_POS_BIT_LEN-1:0] me_x_pos;
  logic [OBJ_Y_POS_BIT_LEN-1:0] me_y_pos;
  logic mode;
  logic move_tick;
  modport master (
    output key_up, key_down, key_left, key_right, enable, powerup,
    input me_x_pos, me_y_pos, mode, move_tick
  );
  modport slave (
    input key_up, key_down, key_left, key_right, enable, powerup,
    output me_x_pos, me_y_pos, mode, move_tick
  );
endinterface

// File: rtl/me_plane_ctrl_key_debounce.sv
// me_plane_ctrl_key_debounce: 2-FF synchroniser then accept a new key level after DEBOUNCE_CYC equal samples
module me_plane_ctrl_key_debounce #(
  parameter int DEBOUNCE_CYC = 250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);
  logic [1:0] sync_ff;
  logic [CW-1:0] cnt;
  logic differ;
  assign differ = sync_ff[1] != level;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_ff <= '0;
      cnt <= '0;
      level <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], key};
      cnt <= (!differ || cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      if (differ && cnt == CNT_MAX) level <= sync_ff[1];
    end
endmodule

// File: rtl/me_plane_ctrl.sv
// me_plane_ctrl: debounced-key plane motion on a divided tick, screen clamping and single/double fire-mode timer
module me_plane_ctrl import me_plane_ctrl_pkg::*; #(
  parameter int DEBOUNCE_CYC = 250_000,
  parameter int MOVE_DIV = MOVE_DIV_DEF,
  parameter int STEP = 2,
  parameter int X_INIT = 295,
  parameter int Y_INIT = 400,
  parameter int X_MAX = H_DISP - ME_WIDTH,
  parameter int Y_MAX = V_DISP - ME_HEIGHT,
  parameter int DOUBLE_TICKS = 2500
) (
  input logic clk,
  input logic rst,
  me_plane_ctrl_if.slave bus
);
  localparam int XW = OBJ_X_POS_BIT_LEN;
  localparam int YW = OBJ_Y_POS_BIT_LEN;
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam int MW = $clog2(MOVE_DIV);
  localparam int TW = $clog2(DOUBLE_TICKS + 1);
  localparam logic [MW-1:0] CNT_END = MW'(MOVE_DIV - 1);
  logic [3:0] raw;
  logic [3:0] db;
  logic [MW-1:0] move_cnt;
  logic tick;
  logic [XW-1:0] x, x_nxt;
  logic [YW-1:0] y, y_nxt;
  logic [XW:0] x_sum;
  logic [YW:0] y_sum;
  logic [0:0] state;
  logic [TW-1:0] timer;
  assign raw = {bus.key_up, bus.key_down, bus.key_left, bus.key_right};
  for (genvar i = 0; i < 4; i++) begin : g_key
    me_plane_ctrl_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
      .clk(clk), .rst(rst), .key(raw[i]), .level(db[i])
    );
  end
  assign tick = bus.enable && move_cnt == CNT_END;
  always_comb begin
    x_sum = {1'b0, x} + XW1'(STEP);
    y_sum = {1'b0, y} + YW1'(STEP);
    x_nxt = (db[1] && !db[0]) ? (x < XW'(STEP) ? '0 : x - XW'(STEP))
          : (db[0] && !db[1]) ? (x_sum > XW1'(X_MAX) ? XW'(X_MAX) : x_sum[XW-1:0])
          : x;
    y_nxt = (db[3] && !db[2]) ? (y < YW'(STEP) ? '0 : y - YW'(STEP))
          : (db[2] && !db[3]) ? (y_sum > YW1'(Y_MAX) ? YW'(Y_MAX) : y_sum[YW-1:0])
          : y;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) move_cnt <= '0;
    else if (bus.enable) move_cnt <= tick ? '0 : move_cnt + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x <= XW'(X_INIT);
      y <= YW'(Y_INIT);
    end else if (tick) begin
      x <= x_nxt;
      y <= y_nxt;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_SINGLE;
      timer <= '0;
    end else if (bus.powerup) begin
      state <= S_DOUBLE;
      timer <= TW'(DOUBLE_TICKS);
    end else if (tick && state == S_DOUBLE) begin
      timer <= timer - 1'b1;
      if (timer == TW'(1)) state <= S_SINGLE;
    end
  assign bus.me_x_pos = x;
  assign bus.me_y_pos = y;
  assign bus.mode = (state == S_DOUBLE) ? BULLET_MODE_DOUBLE : BULLET_MODE_SINGLE;
  assign bus.move_tick = tick;
endmodule
